// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: walks an active-low row strobe, debounces one key
// at a time and emits its hex code with a single-cycle valid strobe.
module keypad_scanner_4x4 #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       col_s1_q, col_s_q;
  logic [3:0]       row_q, row_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             col_hit;
  logic [3:0]       row_next;

  function automatic logic [1:0] row_index(input logic [3:0] row);
    case (row)
      4'b1110: row_index = 2'd0;
      4'b1101: row_index = 2'd1;
      4'b1011: row_index = 2'd2;
      default: row_index = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] low_zero(input logic [3:0] col);
    if (!col[0])      low_zero = 2'd0;
    else if (!col[1]) low_zero = 2'd1;
    else if (!col[2]) low_zero = 2'd2;
    else              low_zero = 2'd3;
  endfunction

  // Row-major keypad legend; '*' and '#' encode as E and F.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
    endcase
  endfunction

  assign col_hit  = ~col_s_q[col_idx_q];
  assign row_next = {row_q[2:0], row_q[3]};

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    div_d     = div_q;
    deb_d     = deb_q;
    row_idx_d = row_idx_q;
    col_idx_d = col_idx_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (col_s_q != 4'hF) begin
            row_idx_d = row_index(row_q);
            col_idx_d = low_zero(col_s_q);
            deb_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            row_d = row_next;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!col_hit) begin
          state_d = SCAN;
          row_d   = row_next;
          div_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          code_d  = key_map(row_idx_q, col_idx_q);
          valid_d = 1'b1;
          held_d  = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      PRESSED: begin
        // Only the latched column matters here; other keys are ignored.
        if (!col_hit) begin
          deb_d   = '0;
          state_d = RELEASE;
        end
      end
      default: begin
        if (col_hit) begin
          deb_d   = '0;
          state_d = PRESSED;
        end else if (deb_q == DEB_LAST) begin
          held_d  = 1'b0;
          row_d   = row_next;
          div_d   = '0;
          state_d = SCAN;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_s1_q  <= 4'hF;
      col_s_q   <= 4'hF;
      state_q   <= SCAN;
      row_q     <= 4'b1110;
      div_q     <= '0;
      deb_q     <= '0;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      code_q    <= 4'h0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      col_s1_q  <= col_in;
      col_s_q   <= col_s1_q;
      state_q   <= state_d;
      row_q     <= row_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign row_out   = row_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
